cube_scan: RTL and testbench
============================

CUBE_SCAN -- requirements
Module: cube_scan

Interface
REQ-001 Parameter SHIFT_DIV, default 2: clk cycles per ser_clk half-period, legal range 1..255.
REQ-002 Parameter LAYER_HOLD, default 1024: clk cycles each layer is displayed, legal range 1..65535.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  scan enable.
REQ-006 frame_cube_flat  in  512  cube image: bit L*64+Y*8+X is the LED at layer L, row Y, column X.
REQ-007 frame_valid  in  1  one-cycle strobe; frame_cube_flat is valid in the same cycle.
REQ-008 ser_data  out  1  serial column data to the shift-register chain.
REQ-009 ser_clk  out  1  shift clock; the chain samples ser_data on its rising edge.
REQ-010 ser_latch  out  1  storage-register latch pulse.
REQ-011 ser_oe_n  out  1  column output enable, active-low.
REQ-012 layer_sel  out  8  one-hot layer driver, active-high.
REQ-013 frame_ack  out  1  one-cycle pulse when a pending frame enters the display buffer.

Function
REQ-014 Capture: on frame_valid=1 with en=1, frame_cube_flat SHALL load into a 512-bit shadow buffer and the pending flag SHALL be set; frame_valid with en=0 SHALL be ignored.
REQ-015 FSM states: IDLE, BLANK, SHIFT, LATCH, SHOW; the layer counter (3 bits) and the bit counter (6 bits) wrap naturally.
REQ-016 IDLE: when en=1, go to BLANK with layer counter 0.
REQ-017 BLANK: lasts 1 cycle with ser_oe_n=1 and layer_sel=0; if layer=0 and pending=1, the display buffer SHALL take the shadow value, frame_ack SHALL pulse, and pending SHALL clear; then go to SHIFT.
REQ-018 If frame_valid coincides with the swap, the display buffer SHALL take the old shadow value; the shadow buffer SHALL take the new frame; pending SHALL remain 1.
REQ-019 SHIFT: 64 bits of the current layer, MSB first (L*64+63 down to L*64+0); each bit is SHIFT_DIV cycles with ser_clk=0 followed by SHIFT_DIV cycles with ser_clk=1; ser_data changes only in the first cycle of the low phase; total 128*SHIFT_DIV cycles; ser_oe_n=1 and layer_sel=0 throughout.
REQ-020 LATCH: ser_latch=1 for exactly 1 cycle, ser_clk=0; then go to SHOW.
REQ-021 SHOW: LAYER_HOLD cycles with ser_oe_n=0 and layer_sel=1<<layer; then increment layer (7 wraps to 0) and go to BLANK.
REQ-022 Layer period SHALL equal 2+128*SHIFT_DIV+LAYER_HOLD cycles; frame period SHALL be 8 times that.
REQ-023 en deasserted in any state SHALL force IDLE on the next edge, with ser_oe_n=1, layer_sel=0, ser_clk=0, ser_latch=0, and layer counter 0; buffers and pending SHALL be retained.
REQ-024 Before the first frame_ack the display buffer holds zeros, so all LEDs are off while scanning.
REQ-025 layer_sel SHALL never have more than one bit set and SHALL be 0 whenever ser_oe_n=1.

Reset
REQ-026 rst=0 SHALL asynchronously clear: state=IDLE, counters=0, shadow, display and pending=0, ser_data=0, ser_clk=0, ser_latch=0, ser_oe_n=1, layer_sel=0, frame_ack=0.
REQ-027 Reset release SHALL take effect on the next clk edge; reset mid-SHIFT or mid-SHOW SHALL abandon the layer with no latch pulse.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, CUBE_BITS=512, LAYER_BITS=64, and NUM_LAYERS=8.
REQ-029 One sub-module, cube_shift_out, SHALL implement the 64-bit serialiser (start, SHIFT_DIV timing, done); the top level holds the buffers, FSM, and layer counter.
REQ-030 All outputs SHALL be driven directly from registers.

Verification (SHIFT_DIV=1, LAYER_HOLD=4)
REQ-031 Reset, then en=1, no frame -> layer period 134 cycles; ser_data=0 throughout; layer_sel goes 01,02,...,80,01.
REQ-032 frame_valid with layer 0 = 64'h8000_0000_0000_0001, other layers 0 -> frame_ack at the next layer-0 BLANK; first ser_data bit 1, bits 2..63 are 0, last bit 1; then 1 ser_latch; then layer_sel=01 for 4 cycles.
REQ-033 frame_valid mid-frame (layer 3) -> layers 3..7 still show the old image; the new image first appears in layer 0 of the next frame; exactly 1 frame_ack.
REQ-034 frame_valid in the same cycle as the swap BLANK -> display takes the earlier frame; pending stays 1; second frame_ack one frame period (1072 cycles) later.
REQ-035 en dropped during SHIFT of layer 5 -> next cycle IDLE with all outputs blanked; en restored -> scan restarts at layer 0 with the buffers intact.
REQ-036 rst asserted during SHOW -> outputs reach reset values without a clk edge; display is all off after release until a new frame arrives.

Source files
------------

// File: rtl/cube_scan_pkg.sv
// =============================================================================
// Module      : cube_scan_pkg
// Description : Shared constants, FSM encoding and helpers for the 8x8x8 LED
//               cube scanner.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package cube_scan_pkg;

    localparam int CUBE_BITS  = 512;
    localparam int LAYER_BITS = 64;
    localparam int NUM_LAYERS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BLANK = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_SHOW  = 3'd4
    } state_t;

    function automatic logic [NUM_LAYERS-1:0] layer_onehot(input logic [2:0] layer);
        logic [NUM_LAYERS-1:0] v;
        v        = '0;
        v[layer] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cube_scan_if.sv
// =============================================================================
// Module      : cube_scan_if
// Description : Frame input handshake plus serial/layer driver outputs of the
//               cube scanner.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface cube_scan_if;
    import cube_scan_pkg::*;

    logic                  en;
    logic [CUBE_BITS-1:0]  frame_cube_flat;
    logic                  frame_valid;
    logic                  frame_ack;
    logic                  ser_data;
    logic                  ser_clk;
    logic                  ser_latch;
    logic                  ser_oe_n;
    logic [NUM_LAYERS-1:0] layer_sel;

    modport master (
        output en, frame_cube_flat, frame_valid,
        input  frame_ack, ser_data, ser_clk, ser_latch, ser_oe_n, layer_sel
    );

    modport slave (
        input  en, frame_cube_flat, frame_valid,
        output frame_ack, ser_data, ser_clk, ser_latch, ser_oe_n, layer_sel
    );

endinterface

`default_nettype wire

// File: rtl/cube_shift_out.sv
// =============================================================================
// Module      : cube_shift_out
// Description : 64-bit MSB-first serialiser with SHIFT_DIV-cycle clock phases.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module cube_shift_out #(
    parameter int SHIFT_DIV = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        start,
    input  wire logic        clear,
    input  wire logic [63:0] data,
    output logic             ser_data,
    output logic             ser_clk,
    output logic             done
);

    localparam logic [7:0] c_div_last = 8'(SHIFT_DIV - 1);

    logic        r_active;
    logic        r_high;
    logic [7:0]  r_div;
    logic [5:0]  r_bit;
    logic [63:0] r_shreg;
    logic        r_ser_data;
    logic        r_ser_clk;
    logic        w_tick;

    assign w_tick   = r_active && (r_div == c_div_last);
    assign done     = w_tick && r_high && (r_bit == 6'd63);
    assign ser_data = r_ser_data;
    assign ser_clk  = r_ser_clk;

    // r_shreg[63] always holds the bit that goes out on the next low phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_high     <= 1'b0;
            r_div      <= '0;
            r_bit      <= '0;
            r_shreg    <= '0;
            r_ser_data <= 1'b0;
            r_ser_clk  <= 1'b0;
        end else if (clear) begin
            r_active  <= 1'b0;
            r_high    <= 1'b0;
            r_div     <= '0;
            r_bit     <= '0;
            r_ser_clk <= 1'b0;
        end else if (start) begin
            r_active   <= 1'b1;
            r_high     <= 1'b0;
            r_div      <= '0;
            r_bit      <= '0;
            r_shreg    <= {data[62:0], 1'b0};
            r_ser_data <= data[63];
            r_ser_clk  <= 1'b0;
        end else if (r_active) begin
            if (!w_tick) begin
                r_div <= r_div + 8'd1;
            end else begin
                r_div <= '0;
                if (!r_high) begin
                    r_high    <= 1'b1;
                    r_ser_clk <= 1'b1;
                end else begin
                    r_high    <= 1'b0;
                    r_ser_clk <= 1'b0;
                    r_bit     <= r_bit + 6'd1;
                    if (r_bit == 6'd63) begin
                        r_active <= 1'b0;
                    end else begin
                        r_ser_data <= r_shreg[63];
                        r_shreg    <= {r_shreg[62:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cube_scan.sv
// =============================================================================
// Module      : cube_scan
// Description : Double-buffered 8x8x8 LED cube scanner: per layer blank, shift
//               64 column bits, latch, then show for LAYER_HOLD cycles.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module cube_scan
    import cube_scan_pkg::*;
#(
    parameter int SHIFT_DIV  = 2,
    parameter int LAYER_HOLD = 1024
) (
    input wire logic   clk,
    input wire logic   rst_n,
    cube_scan_if.slave bus
);

    localparam logic [15:0] c_hold_last = 16'(LAYER_HOLD - 1);

    state_t                r_state;
    state_t                w_state_nx;
    logic [2:0]            r_layer;
    logic [2:0]            w_layer_nx;
    logic [15:0]           r_hold;
    logic [15:0]           w_hold_nx;
    logic [CUBE_BITS-1:0]  r_shadow;
    logic [CUBE_BITS-1:0]  r_display;
    logic                  r_pending;
    logic                  r_frame_ack;
    logic                  r_ser_latch;
    logic                  r_ser_oe_n;
    logic [NUM_LAYERS-1:0] r_layer_sel;
    logic                  w_capture;
    logic                  w_swap;
    logic                  w_start;
    logic                  w_clear;
    logic                  w_done;
    logic [8:0]            w_base;
    logic [LAYER_BITS-1:0] w_layer_word;

    assign w_capture = bus.frame_valid && bus.en;
    assign w_base    = {r_layer, 6'b0};
    // On a swap the serialiser must see the frame that is entering the display
    assign w_layer_word = w_swap ? r_shadow[w_base +: LAYER_BITS]
                                 : r_display[w_base +: LAYER_BITS];

    always_comb begin
        w_state_nx = r_state;
        w_layer_nx = r_layer;
        w_hold_nx  = r_hold;
        w_swap     = 1'b0;
        w_start    = 1'b0;
        w_clear    = 1'b0;
        if (!bus.en) begin
            w_state_nx = ST_IDLE;
            w_layer_nx = '0;
            w_hold_nx  = '0;
            w_clear    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_BLANK;
                    w_layer_nx = '0;
                end
                ST_BLANK: begin
                    w_swap     = (r_layer == 3'd0) && r_pending;
                    w_start    = 1'b1;
                    w_state_nx = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_done) w_state_nx = ST_LATCH;
                end
                ST_LATCH: begin
                    w_state_nx = ST_SHOW;
                    w_hold_nx  = '0;
                end
                ST_SHOW: begin
                    if (r_hold == c_hold_last) begin
                        w_state_nx = ST_BLANK;
                        w_layer_nx = r_layer + 3'd1;
                        w_hold_nx  = '0;
                    end else begin
                        w_hold_nx = r_hold + 16'd1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_layer_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_layer     <= '0;
            r_hold      <= '0;
            r_shadow    <= '0;
            r_display   <= '0;
            r_pending   <= 1'b0;
            r_frame_ack <= 1'b0;
            r_ser_latch <= 1'b0;
            r_ser_oe_n  <= 1'b1;
            r_layer_sel <= '0;
        end else begin
            r_state <= w_state_nx;
            r_layer <= w_layer_nx;
            r_hold  <= w_hold_nx;
            if (w_capture) r_shadow  <= bus.frame_cube_flat;
            if (w_swap)    r_display <= r_shadow;
            // A frame arriving on the swap cycle stays pending for the next frame
            if (w_capture)   r_pending <= 1'b1;
            else if (w_swap) r_pending <= 1'b0;
            r_frame_ack <= w_swap;
            r_ser_latch <= (w_state_nx == ST_LATCH);
            r_ser_oe_n  <= (w_state_nx != ST_SHOW);
            r_layer_sel <= (w_state_nx == ST_SHOW) ? layer_onehot(w_layer_nx) : '0;
        end
    end

    cube_shift_out #(
        .SHIFT_DIV (SHIFT_DIV)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_start),
        .clear    (w_clear),
        .data     (w_layer_word),
        .ser_data (bus.ser_data),
        .ser_clk  (bus.ser_clk),
        .done     (w_done)
    );

    assign bus.frame_ack = r_frame_ack;
    assign bus.ser_latch = r_ser_latch;
    assign bus.ser_oe_n  = r_ser_oe_n;
    assign bus.layer_sel = r_layer_sel;

endmodule

`default_nettype wire

// File: tb/tb_cube_scan.sv
// =============================================================================
// Module      : tb_cube_scan
// Description : Directed self-checking bench for cube_scan (SHIFT_DIV=1,
//               LAYER_HOLD=4, layer period 134 cycles).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_cube_scan;

    logic clk;
    logic rst_n;
    cube_scan_if bus ();

    cube_scan #(
        .SHIFT_DIV  (1),
        .LAYER_HOLD (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observation of the serial chain as an external shift register would see it
    int          cyc = 0;
    int          show_cnt = 0, show_cyc = 0, prev_show_cyc = 0;
    int          ack_cnt = 0, ack_cyc = 0, prev_ack_cyc = 0;
    int          latch_cnt = 0, data_ones = 0, run_len = 0, bad = 0;
    logic [63:0] cap = '0, latched = '0;
    logic [63:0] shown [8];
    logic        prev_sclk = 1'b0;
    logic [7:0]  prev_sel = '0;

    function automatic int sel_idx(input logic [7:0] s);
        int r = 0;
        for (int i = 0; i < 8; i++) if (s[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_sclk <= bus.ser_clk;
        prev_sel  <= bus.layer_sel;
        if (bus.ser_clk && !prev_sclk) cap <= {cap[62:0], bus.ser_data};
        if (bus.ser_data) data_ones <= data_ones + 1;
        if (bus.ser_latch) begin
            latch_cnt <= latch_cnt + 1;
            latched   <= cap;
        end
        if (bus.frame_ack) begin
            ack_cnt      <= ack_cnt + 1;
            ack_cyc      <= cyc;
            prev_ack_cyc <= ack_cyc;
        end
        if (bus.layer_sel != 8'h00) begin
            run_len <= (prev_sel == 8'h00) ? 1 : run_len + 1;
            if (prev_sel == 8'h00) begin
                show_cnt      <= show_cnt + 1;
                show_cyc      <= cyc;
                prev_show_cyc <= show_cyc;
                shown[sel_idx(bus.layer_sel)] <= latched;
            end
        end
        if ((bus.ser_oe_n && bus.layer_sel != 8'h00) || !$onehot0(bus.layer_sel))
            bad <= bad + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_show(output logic [7:0] sel);
        int s = show_cnt;
        int n = 0;
        while (show_cnt == s && n < 2000) begin
            tick();
            n++;
        end
        if (show_cnt == s) check_eq("show_timeout", 64'(show_cnt - s), 64'd1);
        sel = bus.layer_sel;
    endtask

    task automatic wait_sel(input logic [7:0] want);
        logic [7:0] s;
        int n = 0;
        s = 8'h00;
        while (s != want && n < 20) begin
            wait_show(s);
            n++;
        end
        if (s != want) check_eq("sel_timeout", 64'(s), 64'(want));
    endtask

    task automatic wait_blank();
        int n = 0;
        while (bus.layer_sel != 8'h00 && n < 20) begin
            tick();
            n++;
        end
        if (bus.layer_sel != 8'h00) check_eq("blank_timeout", 64'(bus.layer_sel), 64'd0);
    endtask

    task automatic send_frame(input logic [511:0] f);
        bus.frame_cube_flat = f;
        bus.frame_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_valid     = 1'b0;
    endtask

    localparam logic [63:0] A0 = 64'h8000_0000_0000_0001;
    localparam logic [63:0] B0 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] C0 = 64'h0F0F_F0F0_AAAA_5555;
    localparam logic [63:0] C2 = 64'h1234_5678_9ABC_DEF0;

    initial begin
        logic [7:0]   sel;
        logic [511:0] frm;
        int           k, a0, d0, l0;

        for (int i = 0; i < 8; i++) shown[i] = '0;
        rst_n               = 1'b0;
        bus.en              = 1'b0;
        bus.frame_valid     = 1'b0;
        bus.frame_cube_flat = '0;
        repeat (3) tick();
        check_eq("rst_oe_n",  64'(bus.ser_oe_n),  64'd1);
        check_eq("rst_sel",   64'(bus.layer_sel), 64'd0);
        check_eq("rst_sclk",  64'(bus.ser_clk),   64'd0);
        check_eq("rst_latch", 64'(bus.ser_latch), 64'd0);
        check_eq("rst_ack",   64'(bus.frame_ack), 64'd0);
        check_eq("rst_data",  64'(bus.ser_data),  64'd0);

        // Blank scan with no frame: period, layer order, dark data
        rst_n = 1'b1;
        tick();
        bus.en = 1'b1;
        k  = cyc;
        d0 = data_ones;
        wait_show(sel);
        check_eq("first_show_lat", 64'(show_cyc - k), 64'd131);
        check_eq("first_sel", 64'(sel), 64'h01);
        for (int i = 1; i <= 8; i++) begin
            wait_show(sel);
            check_eq("scan_sel", 64'(sel), 64'(8'h01 << (i % 8)));
            check_eq("layer_period", 64'(show_cyc - prev_show_cyc), 64'd134);
        end
        check_eq("dark_data", 64'(data_ones - d0), 64'd0);

        // Frame arriving during layer 3 takes effect at the next layer 0
        wait_sel(8'h08);
        a0  = ack_cnt;
        frm = '0;
        frm[63:0] = A0;
        send_frame(frm);
        for (int i = 4; i < 8; i++) begin
            wait_show(sel);
            check_eq("old_layer", shown[i], 64'd0);
        end
        check_eq("no_early_ack", 64'(ack_cnt - a0), 64'd0);
        wait_show(sel);
        check_eq("a_sel", 64'(sel), 64'h01);
        check_eq("a_word", shown[0], A0);
        check_eq("a_ack_cnt", 64'(ack_cnt - a0), 64'd1);
        check_eq("a_ack_pos", 64'(show_cyc - ack_cyc), 64'd129);
        repeat (6) tick();
        check_eq("show_len", 64'(run_len), 64'd4);

        // Frame on the swap cycle: old shadow displayed, new one stays pending
        wait_sel(8'h20);
        frm = '0;
        frm[63:0] = B0;
        send_frame(frm);
        wait_sel(8'h80);
        wait_blank();
        a0 = ack_cnt;
        frm = '0;
        frm[63:0]    = C0;
        frm[191:128] = C2;
        send_frame(frm);
        wait_show(sel);
        check_eq("b_word", shown[0], B0);
        check_eq("b_ack_cnt", 64'(ack_cnt - a0), 64'd1);
        for (int i = 0; i < 8; i++) wait_show(sel);
        check_eq("c_sel", 64'(sel), 64'h01);
        check_eq("c_word0", shown[0], C0);
        check_eq("c_ack_cnt", 64'(ack_cnt - a0), 64'd2);
        check_eq("c_ack_gap", 64'(ack_cyc - prev_ack_cyc), 64'd1072);
        wait_show(sel);
        wait_show(sel);
        check_eq("c_word2", shown[2], C2);

        // Enable dropped mid-SHIFT of layer 5
        wait_sel(8'h10);
        wait_blank();
        repeat (20) tick();
        bus.en = 1'b0;
        l0 = latch_cnt;
        a0 = ack_cnt;
        @(posedge clk);
        #1;
        check_eq("en_oe_n",  64'(bus.ser_oe_n),  64'd1);
        check_eq("en_sel",   64'(bus.layer_sel), 64'd0);
        check_eq("en_sclk",  64'(bus.ser_clk),   64'd0);
        check_eq("en_latch", 64'(bus.ser_latch), 64'd0);
        repeat (10) tick();
        check_eq("en_no_latch", 64'(latch_cnt - l0), 64'd0);
        bus.en = 1'b1;
        k = cyc;
        wait_show(sel);
        check_eq("re_sel", 64'(sel), 64'h01);
        check_eq("re_lat", 64'(show_cyc - k), 64'd131);
        check_eq("re_word", shown[0], C0);
        check_eq("re_no_ack", 64'(ack_cnt - a0), 64'd0);

        // Asynchronous reset during SHOW
        rst_n = 1'b0;
        #1;
        check_eq("arst_oe_n", 64'(bus.ser_oe_n),  64'd1);
        check_eq("arst_sel",  64'(bus.layer_sel), 64'd0);
        check_eq("arst_data", 64'(bus.ser_data),  64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        d0 = data_ones;
        l0 = latch_cnt;
        a0 = ack_cnt;
        for (int i = 0; i < 8; i++) wait_show(sel);
        check_eq("post_rst_word", shown[0], 64'd0);
        check_eq("post_rst_data", 64'(data_ones - d0), 64'd0);
        check_eq("post_rst_latch", 64'(latch_cnt - l0), 64'd8);
        check_eq("post_rst_ack", 64'(ack_cnt - a0), 64'd0);
        check_eq("sel_invariant", 64'(bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
